// File: rtl/level_renderer.sv
// level_renderer
//   640x480 VGA renderer for a tile-based level with three sprites.
//   Scan counters walk an 800x525 frame.  Tile row/col come from
//   BLOCK_WIDTH-sized sub-counters, so no divider is needed.  A two-stage
//   pipeline looks up the tile and sprite hits in stage 1 and resolves the
//   colour in stage 2.  Sync and blank are delayed by two cycles so they
//   stay aligned with rgb.
//
// Ports
//   vga_clock    pixel clock, the only clock
//   reset        asynchronous, active-low reset
//   background   tile map, background[row][col], 8-bit tile codes
//   mario_*, goomba_*, goomba_2*   sprite top-left positions (signed 32-bit)
//   win, lose    level state overlays
//   hsync/vsync  active-low syncs
//   blank_n      high while rgb carries an active pixel
//   rgb          4:4:4 colour
//   frame_start  one-cycle pulse when the output pixel is (0,0)
module level_renderer #(
  parameter logic [7:0] BDR = 8'd0,
  parameter logic [7:0] SKY = 8'd1,
  parameter logic [7:0] BLK = 8'd2,
  parameter logic [7:0] GND = 8'd3,
  parameter logic [7:0] TKN = 8'd4,
  parameter logic [7:0] CK1 = 8'd5,
  parameter logic [7:0] CK2 = 8'd6,
  parameter int CHARACTER_WIDTH = 42,
  parameter int SCREEN_WIDTH    = 640,
  parameter int SCREEN_HEIGHT   = 480,
  parameter int BLOCK_WIDTH     = 40
) (
  input  logic                     vga_clock,
  input  logic                     reset,
  input  logic [11:0][16:0][7:0]   background,
  input  logic signed [31:0]       mario_x,
  input  logic signed [31:0]       mario_y,
  input  logic signed [31:0]       goomba_x,
  input  logic signed [31:0]       goomba_y,
  input  logic signed [31:0]       goomba_2x,
  input  logic signed [31:0]       goomba_2y,
  input  logic                     win,
  input  logic                     lose,
  output logic                     hsync,
  output logic                     vsync,
  output logic                     blank_n,
  output logic [11:0]              rgb,
  output logic                     frame_start
);

  localparam logic [9:0] H_LAST       = 10'd799;
  localparam logic [9:0] V_LAST       = 10'd524;
  localparam logic [9:0] H_SYNC_FIRST = 10'd656;
  localparam logic [9:0] H_SYNC_LAST  = 10'd751;
  localparam logic [9:0] V_SYNC_FIRST = 10'd490;
  localparam logic [9:0] V_SYNC_LAST  = 10'd491;
  localparam logic [9:0] H_ACTIVE     = 10'(SCREEN_WIDTH);
  localparam logic [9:0] V_ACTIVE     = 10'(SCREEN_HEIGHT);

  localparam int              SUB_W    = $clog2(BLOCK_WIDTH);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(BLOCK_WIDTH - 1);

  // Parking position: far off-screen, so nothing is drawn before the first latch.
  localparam logic signed [31:0] OFF_SCREEN = 32'sd1000;

  localparam logic [11:0] C_LOSE   = 12'hF00;
  localparam logic [11:0] C_WIN    = 12'h0F0;
  localparam logic [11:0] C_MARIO  = 12'hF00;
  localparam logic [11:0] C_GOOMBA = 12'h840;

  // ---------------------------------------------------------------------------
  // Scan counters and tile-coordinate sub-counters
  // ---------------------------------------------------------------------------
  logic [9:0]       hc, vc;
  logic [SUB_W-1:0] hsub, vsub;
  logic [4:0]       col;   // reaches 19 in horizontal blanking
  logic [3:0]       row;   // reaches 13 in vertical blanking

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would let one counter see another's update.
  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      hc   <= '0;
      vc   <= '0;
      hsub <= '0;
      vsub <= '0;
      col  <= '0;
      row  <= '0;
    end else if (hc == H_LAST) begin
      hc   <= '0;
      hsub <= '0;
      col  <= '0;
      if (vc == V_LAST) begin
        vc   <= '0;
        vsub <= '0;
        row  <= '0;
      end else begin
        vc <= vc + 10'd1;
        if (vsub == SUB_LAST) begin
          vsub <= '0;
          row  <= row + 4'd1;
        end else begin
          vsub <= vsub + 1'b1;
        end
      end
    end else begin
      hc <= hc + 10'd1;
      if (hsub == SUB_LAST) begin
        hsub <= '0;
        col  <= col + 5'd1;
      end else begin
        hsub <= hsub + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame-synchronous snapshot of sprite positions and overlays.
  // Taken at the first vblank pixel so a frame is always drawn from one set.
  // ---------------------------------------------------------------------------
  logic signed [31:0] mario_x_l, mario_y_l, goomba_x_l, goomba_y_l;
  logic signed [31:0] goomba_2x_l, goomba_2y_l;
  logic               win_l, lose_l;

  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      mario_x_l   <= OFF_SCREEN;
      mario_y_l   <= OFF_SCREEN;
      goomba_x_l  <= OFF_SCREEN;
      goomba_y_l  <= OFF_SCREEN;
      goomba_2x_l <= OFF_SCREEN;
      goomba_2y_l <= OFF_SCREEN;
      win_l       <= 1'b0;
      lose_l      <= 1'b0;
    end else if (hc == 10'd0 && vc == V_ACTIVE) begin
      mario_x_l   <= mario_x;
      mario_y_l   <= mario_y;
      goomba_x_l  <= goomba_x;
      goomba_y_l  <= goomba_y;
      goomba_2x_l <= goomba_2x;
      goomba_2y_l <= goomba_2y;
      win_l       <= win;
      lose_l      <= lose;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 0: combinational decode of the current scan position
  // ---------------------------------------------------------------------------
  function automatic logic sprite_hit(input logic signed [31:0] px,
                                      input logic signed [31:0] py,
                                      input logic signed [31:0] sx,
                                      input logic signed [31:0] sy);
    return (sx >= px) && (sx < px + CHARACTER_WIDTH) &&
           (sy >= py) && (sy < py + CHARACTER_WIDTH);
  endfunction

  logic signed [31:0] hc_s, vc_s;
  logic               active_s0, hsync_s0, vsync_s0, first_s0;
  logic               mario_s0, goomba_s0;
  logic [7:0]         tile_s0;

  assign hc_s = {22'd0, hc};
  assign vc_s = {22'd0, vc};

  // NOTE: every always_comb output is given a default before any branch so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    active_s0 = (hc < H_ACTIVE) && (vc < V_ACTIVE);
    hsync_s0  = !((hc >= H_SYNC_FIRST) && (hc <= H_SYNC_LAST));
    vsync_s0  = !((vc >= V_SYNC_FIRST) && (vc <= V_SYNC_LAST));
    first_s0  = (hc == 10'd0) && (vc == 10'd0);
    mario_s0  = sprite_hit(mario_x_l, mario_y_l, hc_s, vc_s);
    goomba_s0 = sprite_hit(goomba_x_l, goomba_y_l, hc_s, vc_s) ||
                sprite_hit(goomba_2x_l, goomba_2y_l, hc_s, vc_s);
    tile_s0   = BDR;
    // Inside the active area col stays in 0..15, so the spare column 16 of the
    // map is never read for display.
    if (active_s0) tile_s0 = background[row][col];
  end

  // ---------------------------------------------------------------------------
  // Stage 1: tile code, hit flags, active and sync
  // ---------------------------------------------------------------------------
  logic [7:0] tile_s1;
  logic       mario_s1, goomba_s1, active_s1, hsync_s1, vsync_s1, first_s1;

  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      tile_s1   <= '0;
      mario_s1  <= 1'b0;
      goomba_s1 <= 1'b0;
      active_s1 <= 1'b0;
      hsync_s1  <= 1'b1;
      vsync_s1  <= 1'b1;
      first_s1  <= 1'b0;
    end else begin
      tile_s1   <= tile_s0;
      mario_s1  <= mario_s0;
      goomba_s1 <= goomba_s0;
      active_s1 <= active_s0;
      hsync_s1  <= hsync_s0;
      vsync_s1  <= vsync_s0;
      first_s1  <= first_s0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: colour resolution and output registers
  // ---------------------------------------------------------------------------
  function automatic logic [11:0] tile_colour(input logic [7:0] code);
    case (code)
      BDR:     return 12'h000;
      SKY:     return 12'h5AF;
      BLK:     return 12'hA52;
      GND:     return 12'h6A2;
      TKN:     return 12'hFD0;
      CK1:     return 12'h888;
      CK2:     return 12'hFFF;
      default: return 12'hF0F;
    endcase
  endfunction

  logic [11:0] pixel_s1;

  always_comb begin
    pixel_s1 = 12'h000;
    if (active_s1) begin
      if (lose_l)         pixel_s1 = C_LOSE;
      else if (win_l)     pixel_s1 = C_WIN;
      else if (mario_s1)  pixel_s1 = C_MARIO;
      else if (goomba_s1) pixel_s1 = C_GOOMBA;
      else                pixel_s1 = tile_colour(tile_s1);
    end
  end

  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      rgb         <= 12'h000;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      blank_n     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      rgb         <= pixel_s1;
      hsync       <= hsync_s1;
      vsync       <= vsync_s1;
      blank_n     <= active_s1;
      frame_start <= first_s1;
    end
  end

endmodule

// File: tb/tb_level_renderer.sv
// tb_level_renderer
//   Self-checking bench for level_renderer.  A pixel-level reference model
//   derives every output from the scan position (plain division/modulo),
//   the tile map and the per-frame sprite snapshot; a compare process checks
//   the DUT against it every cycle.  Directed literal checks pin the model.
module tb_level_renderer;

  localparam int H_TOT   = 800;
  localparam int V_TOT   = 525;
  localparam int FRAME   = H_TOT * V_TOT;
  localparam int LATENCY = 2;
  localparam int MAX_ERR = 50;
  localparam int WAIT_LIMIT = 500000;

  logic                   vga_clock = 1'b0;
  logic                   reset     = 1'b0;
  logic [11:0][16:0][7:0] background;
  int                     mario_x, mario_y, goomba_x, goomba_y, goomba_2x, goomba_2y;
  logic                   win, lose;
  logic                   hsync, vsync, blank_n, frame_start;
  logic [11:0]            rgb;

  level_renderer dut (
    .vga_clock   (vga_clock),
    .reset       (reset),
    .background  (background),
    .mario_x     (mario_x),
    .mario_y     (mario_y),
    .goomba_x    (goomba_x),
    .goomba_y    (goomba_y),
    .goomba_2x   (goomba_2x),
    .goomba_2y   (goomba_2y),
    .win         (win),
    .lose        (lose),
    .hsync       (hsync),
    .vsync       (vsync),
    .blank_n     (blank_n),
    .rgb         (rgb),
    .frame_start (frame_start)
  );

  always #5 vga_clock = ~vga_clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic finish_run();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
      if (n_errors >= MAX_ERR) finish_run();
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        valid;
    int          hc;
    int          vc;
    logic        hs;
    logic        vs;
    logic        bl;
    logic        fs;
    logic [11:0] rgb;
  } exp_t;

  localparam exp_t RST_EXP = '{valid: 1'b0, hc: 0, vc: 0, hs: 1'b1, vs: 1'b1,
                               bl: 1'b0, fs: 1'b0, rgb: 12'h000};

  // Snapshot of the sprite/overlay inputs, as the frame currently displays them.
  longint m_mx, m_my, m_gx, m_gy, m_g2x, m_g2y;
  logic   m_win, m_lose;

  function automatic logic [11:0] colour_of(input logic [7:0] code);
    case (code)
      8'd0:    return 12'h000;
      8'd1:    return 12'h5AF;
      8'd2:    return 12'hA52;
      8'd3:    return 12'h6A2;
      8'd4:    return 12'hFD0;
      8'd5:    return 12'h888;
      8'd6:    return 12'hFFF;
      default: return 12'hF0F;
    endcase
  endfunction

  function automatic logic inside_box(input longint x0, input longint y0,
                                      input int x, input int y);
    return (x >= x0) && (x < x0 + 42) && (y >= y0) && (y < y0 + 42);
  endfunction

  function automatic exp_t model_pix(input int n);
    exp_t e;
    e       = RST_EXP;
    e.valid = 1'b1;
    e.hc    = n % H_TOT;
    e.vc    = n / H_TOT;
    e.hs    = !(e.hc >= 656 && e.hc <= 751);
    e.vs    = !(e.vc == 490 || e.vc == 491);
    e.fs    = (e.hc == 0) && (e.vc == 0);
    e.bl    = (e.hc < 640) && (e.vc < 480);
    e.rgb   = 12'h000;
    if (e.bl) begin
      if (m_lose)                                     e.rgb = 12'hF00;
      else if (m_win)                                 e.rgb = 12'h0F0;
      else if (inside_box(m_mx, m_my, e.hc, e.vc))    e.rgb = 12'hF00;
      else if (inside_box(m_gx, m_gy, e.hc, e.vc) ||
               inside_box(m_g2x, m_g2y, e.hc, e.vc))  e.rgb = 12'h840;
      else e.rgb = colour_of(background[e.vc / 40][e.hc / 40]);
    end
    return e;
  endfunction

  exp_t exp_s1 = RST_EXP;
  exp_t exp_out = RST_EXP;
  int   scan_n = 0;   // index of the pixel the DUT is decoding this cycle

  always @(posedge vga_clock) begin
    if (!reset) begin
      scan_n  = 0;
      exp_s1  = RST_EXP;
      exp_out = RST_EXP;
      m_mx = 1000; m_my = 1000; m_gx = 1000; m_gy = 1000; m_g2x = 1000; m_g2y = 1000;
      m_win = 1'b0; m_lose = 1'b0;
    end else begin
      exp_out = exp_s1;
      exp_s1  = model_pix(scan_n);
      if (scan_n == 480 * H_TOT) begin
        m_mx = mario_x;   m_my = mario_y;
        m_gx = goomba_x;  m_gy = goomba_y;
        m_g2x = goomba_2x; m_g2y = goomba_2y;
        m_win = win; m_lose = lose;
      end
      scan_n = (scan_n + 1) % FRAME;
    end
  end

  // ---------------------------------------------------------------------------
  // Every-cycle comparison against the model
  // ---------------------------------------------------------------------------
  logic cmp_en = 1'b0;

  always @(negedge vga_clock) begin
    if (cmp_en) begin
      exp_t e;
      e = reset ? exp_out : RST_EXP;
      check($sformatf("pixel(%0d,%0d) {hs,vs,bl,fs,rgb}", e.hc, e.vc),
            {16'd0, hsync, vsync, blank_n, frame_start, rgb},
            {16'd0, e.hs, e.vs, e.bl, e.fs, e.rgb});
    end
  end

  // ---------------------------------------------------------------------------
  // Sync and frame timing measured directly on the outputs
  // ---------------------------------------------------------------------------
  int   hs_low, hs_per, vs_low, vs_per, fs_per;
  logic hs_prev, vs_prev, hs_seen, vs_seen, fs_seen;

  always @(negedge vga_clock) begin
    if (!reset) begin
      hs_low = 0; hs_per = 0; vs_low = 0; vs_per = 0; fs_per = 0;
      hs_prev = 1'b1; vs_prev = 1'b1;
      hs_seen = 1'b0; vs_seen = 1'b0; fs_seen = 1'b0;
    end else begin
      hs_per++; vs_per++; fs_per++;
      if (!hsync) hs_low++;
      if (hsync && !hs_prev) begin
        check("hsync low length", hs_low, 96);
        hs_low = 0;
      end
      if (!hsync && hs_prev) begin
        if (hs_seen) check("hsync period", hs_per, H_TOT);
        hs_seen = 1'b1;
        hs_per  = 0;
      end
      if (!vsync) vs_low++;
      if (vsync && !vs_prev) begin
        check("vsync low length", vs_low, 2 * H_TOT);
        vs_low = 0;
      end
      if (!vsync && vs_prev) begin
        if (vs_seen) check("vsync period", vs_per, FRAME);
        vs_seen = 1'b1;
        vs_per  = 0;
      end
      if (frame_start) begin
        if (fs_seen) check("frame_start period", fs_per, FRAME);
        fs_seen = 1'b1;
        fs_per  = 0;
      end
      hs_prev = hsync;
      vs_prev = vsync;
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  task automatic wait_out(input int x, input int y, output int cycles);
    cycles = 0;
    do begin
      @(negedge vga_clock);
      cycles++;
    end while (!(exp_out.valid && reset && exp_out.hc == x && exp_out.vc == y) &&
               cycles < WAIT_LIMIT);
    if (cycles >= WAIT_LIMIT) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait for output pixel (%0d,%0d): timed out after %0d cycles", x, y, cycles);
      finish_run();
    end
  endtask

  task automatic expect_rgb(input int x, input int y, input logic [11:0] col);
    int c;
    wait_out(x, y, c);
    check($sformatf("rgb at (%0d,%0d)", x, y), {20'd0, rgb}, {20'd0, col});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " hsync"},       {31'd0, hsync},       32'd1);
    check({tag, " vsync"},       {31'd0, vsync},       32'd1);
    check({tag, " blank_n"},     {31'd0, blank_n},     32'd0);
    check({tag, " rgb"},         {20'd0, rgb},         32'h000);
    check({tag, " frame_start"}, {31'd0, frame_start}, 32'd0);
  endtask

  initial begin
    int c;
    for (int r = 0; r < 12; r++)
      for (int k = 0; k < 17; k++)
        background[r][k] = 8'd1;
    background[0][0]   = 8'd2;
    background[0][1]   = 8'd3;
    background[11][15] = 8'd4;
    mario_x = 100;  mario_y = 200;
    goomba_x = 120; goomba_y = 200;
    goomba_2x = 1000; goomba_2y = 1000;
    win = 1'b0; lose = 1'b0;

    repeat (4) @(negedge vga_clock);
    cmp_en = 1'b1;
    check_reset_outputs("in reset");

    // Frame A: sprites still parked, only the tile map shows.
    #1 reset = 1'b1;
    wait_out(0, 0, c);
    check("latency release->(0,0)", c, LATENCY);
    check("(0,0) rgb", {20'd0, rgb}, 32'hA52);
    check("(0,0) frame_start", {31'd0, frame_start}, 32'd1);
    expect_rgb(40, 0, 12'h6A2);
    expect_rgb(39, 39, 12'hA52);
    expect_rgb(40, 40, 12'h5AF);
    expect_rgb(639, 479, 12'hFD0);

    // Frame B: mario (100,200), goomba (120,200); goomba_2 off-screen.
    wait_out(0, 100, c);
    #1 mario_x = 300;
    expect_rgb(100, 200, 12'hF00);
    expect_rgb(142, 200, 12'h840);
    expect_rgb(161, 200, 12'h840);
    expect_rgb(162, 200, 12'h5AF);
    expect_rgb(141, 241, 12'hF00);
    wait_out(0, 300, c);
    #1;
    goomba_x  = int'($urandom_range(0, 760)) - 60;
    goomba_y  = int'($urandom_range(300, 470));
    goomba_2x = int'($urandom_range(0, 760)) - 60;
    goomba_2y = int'($urandom_range(300, 470));

    // Frame C: mario moved to x=300; goombas placed randomly below row 300.
    expect_rgb(100, 200, 12'h5AF);
    expect_rgb(300, 200, 12'hF00);
    expect_rgb(342, 200, 12'h5AF);
    expect_rgb(341, 241, 12'hF00);
    wait_out(0, 300, c);
    #1;
    for (int r = 8; r < 12; r++)
      for (int k = 0; k < 17; k++)
        background[r][k] = 8'($urandom_range(0, 9));
    win = 1'b1;

    // Frame D: win overlay.
    expect_rgb(0, 0, 12'h0F0);
    wait_out(700, 100, c);
    check("win frame blanking rgb", {20'd0, rgb}, 32'h000);
    check("win frame blanking blank_n", {31'd0, blank_n}, 32'd0);
    wait_out(0, 200, c);
    #1 lose = 1'b1;
    expect_rgb(639, 479, 12'h0F0);

    // Frame E: win and lose both latched, lose takes priority.
    expect_rgb(0, 0, 12'hF00);
    wait_out(645, 10, c);
    check("lose frame blanking rgb", {20'd0, rgb}, 32'h000);
    expect_rgb(320, 240, 12'hF00);

    // Mid-frame reset aborts the frame at once; snapshot returns to defaults.
    wait_out(0, 250, c);
    #1 reset = 1'b0;
    #1 check_reset_outputs("mid-frame reset");
    @(negedge vga_clock);
    #1 reset = 1'b1;
    wait_out(0, 0, c);
    check("latency re-release->(0,0)", c, LATENCY);
    check("(0,0) after reset rgb", {20'd0, rgb}, 32'hA52);
    check("(0,0) after reset frame_start", {31'd0, frame_start}, 32'd1);
    repeat (10) @(negedge vga_clock);

    finish_run();
  end

endmodule
